// File: rtl/mem_responder_if.sv
// Four-phase memory handshake between the load/store FSM (master) and the
// memory responder (slave).
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              MemEN;
    logic              RW;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] dataOut;
    logic              MFC;
    logic              busy;
    logic              addrErr;

    modport master (
        output MemEN, RW, address, dataIn,
        input  dataOut, MFC, busy, addrErr
    );

    modport slave (
        input  MemEN, RW, address, dataIn,
        output dataOut, MFC, busy, addrErr
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: captures a request on MemEN, performs it on a word
// array after LATENCY cycles, then holds MFC until MemEN is released.
module mem_responder #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 3
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);
    localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              mfc_q, mfc_d;
    logic              aerr_q, aerr_d;
    logic              fire;
    logic              in_range;
    logic              we;
    logic [IDX_W-1:0]  idx;

    logic [DATA_W-1:0] mem [DEPTH];

    // Upper address bits only take part in the range check.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];
    assign we       = fire & rw_q & in_range;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            rw_q   <= 1'b0;
            din_q  <= '0;
            dout_q <= '0;
            mfc_q  <= 1'b0;
            aerr_q <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            addr_q <= addr_d;
            rw_q   <= rw_d;
            din_q  <= din_d;
            dout_q <= dout_d;
            mfc_q  <= mfc_d;
            aerr_q <= aerr_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        rw_d    = rw_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        aerr_d  = aerr_q;
        fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.MemEN) begin
                    addr_d  = bus.address;
                    rw_d    = bus.RW;
                    din_d   = bus.dataIn;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    fire    = 1'b1;
                    mfc_d   = 1'b1;
                    aerr_d  = ~in_range;
                    state_d = DONE;
                    if (!rw_q) dout_d = in_range ? mem[idx] : '0;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            DONE: begin
                if (!bus.MemEN) begin
                    mfc_d   = 1'b0;
                    aerr_d  = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // No reset on the array; a reset mid-access forces state to IDLE, which
    // kills the write enable before the edge that would have committed it.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= din_q;
    end

    assign bus.dataOut = dout_q;
    assign bus.MFC     = mfc_q;
    assign bus.addrErr = aerr_q;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: handshake timing, range errors, input
// churn, mid-transaction reset and back-to-back requests.
module tb_mem_responder;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   lat;
    int   n;

    mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(64), .LATENCY(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise a request, step through the accept edge, then count cycles to MFC.
    task automatic start_req(input logic rw, input logic [15:0] a, input logic [15:0] d,
                             output int cycles);
        bus.MemEN   = 1'b1;
        bus.RW      = rw;
        bus.address = a;
        bus.dataIn  = d;
        step();
        cycles = 0;
        while (!bus.MFC && cycles < 20) begin
            step();
            cycles++;
        end
    endtask

    task automatic finish_req();
        bus.MemEN = 1'b0;
        step();
        step();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        int c;
        start_req(1'b1, a, d, c);
        finish_req();
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        int c;
        start_req(1'b0, a, 16'h0000, c);
        check({tag, "_lat"}, c, 3);
        check({tag, "_data"}, {16'h0, bus.dataOut}, {16'h0, exp});
        check({tag, "_aerr"}, {31'h0, bus.addrErr}, 32'h0);
        finish_req();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        bus.MemEN   = 1'b0;
        bus.RW      = 1'b0;
        bus.address = '0;
        bus.dataIn  = '0;
        step();
        step();
        check("rst_mfc",  {31'h0, bus.MFC},     32'h0);
        check("rst_busy", {31'h0, bus.busy},    32'h0);
        check("rst_aerr", {31'h0, bus.addrErr}, 32'h0);
        check("rst_dout", {16'h0, bus.dataOut}, 32'h0);
        reset = 1'b1;
        step();

        // Write then read back
        start_req(1'b1, 16'h0005, 16'hBEEF, lat);
        check("wr5_lat",  lat, 3);
        check("wr5_busy", {31'h0, bus.busy}, 32'h1);
        finish_req();
        read_check("rd5", 16'h0005, 16'hBEEF);

        // MFC held while MemEN stays high
        start_req(1'b0, 16'h0005, 16'h0000, lat);
        check("hold_lat", lat, 3);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_mfc", {31'h0, bus.MFC}, 32'h1);
        end
        check("hold_dout", {16'h0, bus.dataOut}, 32'h0000BEEF);
        bus.MemEN = 1'b0;
        step();
        check("fall_mfc",  {31'h0, bus.MFC},  32'h0);
        check("fall_busy", {31'h0, bus.busy}, 32'h1);
        step();
        check("idle_busy", {31'h0, bus.busy}, 32'h0);

        // Out-of-range accesses
        do_write(16'h0000, 16'h1111);
        start_req(1'b0, 16'h0040, 16'h0000, lat);
        check("oor_rd_lat",  lat, 3);
        check("oor_rd_aerr", {31'h0, bus.addrErr}, 32'h1);
        check("oor_rd_dout", {16'h0, bus.dataOut}, 32'h0);
        bus.MemEN = 1'b0;
        step();
        check("oor_aerr_clr", {31'h0, bus.addrErr}, 32'h0);
        step();
        start_req(1'b1, 16'h0040, 16'h9999, lat);
        check("oor_wr_aerr", {31'h0, bus.addrErr}, 32'h1);
        finish_req();
        read_check("rd0", 16'h0000, 16'h1111);
        start_req(1'b1, 16'h0007, 16'h7777, lat);
        check("wr_keeps_dout", {16'h0, bus.dataOut}, 32'h00001111);
        finish_req();

        // Input churn during ACCESS
        do_write(16'h0002, 16'h5555);
        do_write(16'h0003, 16'h0000);
        do_write(16'h0004, 16'h4444);
        bus.MemEN   = 1'b1;
        bus.RW      = 1'b1;
        bus.address = 16'h0003;
        bus.dataIn  = 16'h1234;
        step();
        lat = 0;
        while (!bus.MFC && lat < 20) begin
            bus.address = 16'h0004 + 16'(lat);
            bus.dataIn  = 16'hDEAD + 16'(lat);
            step();
            lat++;
        end
        check("churn_lat", lat, 3);
        finish_req();
        read_check("churn_w3", 16'h0003, 16'h1234);
        read_check("churn_w4", 16'h0004, 16'h4444);
        read_check("churn_w5", 16'h0005, 16'hBEEF);
        read_check("churn_w2", 16'h0002, 16'h5555);

        // Reset the cycle before MFC of a write
        bus.MemEN   = 1'b1;
        bus.RW      = 1'b1;
        bus.address = 16'h0002;
        bus.dataIn  = 16'hAAAA;
        step();
        step();
        step();
        check("pre_rst_mfc", {31'h0, bus.MFC}, 32'h0);
        reset = 1'b0;
        #1;
        check("midrst_mfc",  {31'h0, bus.MFC},     32'h0);
        check("midrst_busy", {31'h0, bus.busy},    32'h0);
        check("midrst_dout", {16'h0, bus.dataOut}, 32'h0);
        step();
        check("midrst_mfc2", {31'h0, bus.MFC}, 32'h0);
        bus.MemEN = 1'b0;
        reset     = 1'b1;
        step();
        read_check("rst_w2", 16'h0002, 16'h5555);

        // Back-to-back: MemEN re-raised during RELEASE
        start_req(1'b0, 16'h0003, 16'h0000, lat);
        check("b2b_a_data", {16'h0, bus.dataOut}, 32'h00001234);
        bus.MemEN = 1'b0;
        step();
        bus.MemEN   = 1'b1;
        bus.RW      = 1'b0;
        bus.address = 16'h0004;
        check("b2b_rel_busy", {31'h0, bus.busy}, 32'h1);
        check("b2b_rel_mfc",  {31'h0, bus.MFC},  32'h0);
        step();
        n = 1;
        check("b2b_idle_busy", {31'h0, bus.busy}, 32'h0);
        step();
        n++;
        check("b2b_acc_busy", {31'h0, bus.busy}, 32'h1);
        while (!bus.MFC && n < 30) begin
            step();
            n++;
        end
        check("b2b_spacing", n, 5);
        check("b2b_b_data", {16'h0, bus.dataOut}, 32'h00004444);
        finish_req();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
